// File: rtl/risc_v_pkg.sv
// risc_v_pkg: shared opcodes, funct3 codes, FSM states and access-legality helpers
package risc_v_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // Illegal funct3 for the access kind, or a halfword/word not naturally aligned
    function automatic logic access_error(input logic is_load, input logic [2:0] f3,
                                          input logic [1:0] a);
        return (f3 == F3_B || (is_load && f3 == F3_BU)) ? 1'b0 :
               (f3 == F3_H || (is_load && f3 == F3_HU)) ? a[0] :
               (f3 == F3_W) ? (a != 2'b00) : 1'b1;
    endfunction

    // Lanes touched by a byte, halfword or word at byte offset a
    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] a);
        return (f3[1:0] == 2'b00) ? 4'b0001 << a :
               (f3[1:0] == 2'b01) ? 4'b0011 << a : 4'b1111;
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed lane of a read word and sign/zero-extends it
module load_align
    import risc_v_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {addr, 3'b000};

    // Extend the low byte/halfword of the shifted word according to the load type
    always_comb begin
        data = (funct3 == F3_B)  ? {{24{shifted[7]}}, shifted[7:0]} :
               (funct3 == F3_H)  ? {{16{shifted[15]}}, shifted[15:0]} :
               (funct3 == F3_W)  ? shifted :
               (funct3 == F3_BU) ? {24'h0, shifted[7:0]} :
               (funct3 == F3_HU) ? {16'h0, shifted[15:0]} : 32'h0;
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage issuing aligned loads/stores with timeout and write-back pulse
module mem_access_unit
    import risc_v_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_ir,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_b,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_ir,
    output logic [31:0] wb_alu_out,
    output logic [31:0] wb_load_data,
    output logic        wb_error
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_t state, next;
    logic [31:0] pc_r, ir_r, alu_r, b_r, load_r, aligned;
    logic [CW-1:0] cnt;
    logic err_r, accept, is_load_in, is_mem_in, bad_in, is_store, timeout_hit;
    logic [2:0] f3;

    assign accept      = ex_valid && ex_ready;
    assign is_load_in  = ex_ir[6:0] == OP_LOAD;
    assign is_mem_in   = is_load_in || ex_ir[6:0] == OP_STORE;
    assign bad_in      = is_mem_in && access_error(is_load_in, ex_ir[14:12], ex_alu_out[1:0]);
    assign f3          = ir_r[14:12];
    assign is_store    = ir_r[6:0] == OP_STORE;
    assign timeout_hit = cnt == LAST;

    load_align u_align (
        .rdata  (mem_rdata),
        .addr   (alu_r[1:0]),
        .funct3 (f3),
        .data   (aligned)
    );

    // State register; reset abandons any in-flight request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    // Next state: legal memory ops wait for ack or timeout, everything else responds directly
    always_comb begin
        next = state;
        if (state == IDLE && accept)                        next = (is_mem_in && !bad_in) ? ACCESS : RESP;
        else if (state == ACCESS && (mem_ack || timeout_hit)) next = RESP;
        else if (state == RESP)                             next = IDLE;
    end

    // Count waiting cycles in ACCESS; restarts whenever the unit leaves ACCESS
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= (state == ACCESS && !mem_ack && !timeout_hit) ? cnt + CW'(1) : '0;
    end

    // Capture the instruction on accept and the load result / timeout error during ACCESS
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r   <= '0;
            ir_r   <= '0;
            alu_r  <= '0;
            b_r    <= '0;
            load_r <= '0;
            err_r  <= 1'b0;
        end else if (accept) begin
            pc_r   <= ex_pc;
            ir_r   <= ex_ir;
            alu_r  <= ex_alu_out;
            b_r    <= ex_b;
            load_r <= '0;
            err_r  <= bad_in;
        end else if (state == ACCESS) begin
            if (mem_ack && !is_store) load_r <= aligned;
            if (!mem_ack && timeout_hit) err_r <= 1'b1;
        end
    end

    assign ex_ready     = state == IDLE;
    assign mem_req      = state == ACCESS;
    assign mem_we       = mem_req && is_store;
    assign mem_addr     = mem_req ? {alu_r[31:2], 2'b00} : 32'h0;
    assign mem_be       = mem_req ? byte_enable(f3, alu_r[1:0]) : 4'h0;
    assign mem_wdata    = !mem_we ? 32'h0 :
                          (f3[1:0] == 2'b00) ? {4{b_r[7:0]}} :
                          (f3[1:0] == 2'b01) ? {2{b_r[15:0]}} : b_r;
    assign wb_valid     = state == RESP;
    assign wb_pc        = pc_r;
    assign wb_ir        = ir_r;
    assign wb_alu_out   = alu_r;
    assign wb_load_data = load_r;
    assign wb_error     = err_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized and directed checks of mem_access_unit against a byte-level model
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        ex_valid = 1'b0, ex_ready;
    logic [31:0] ex_pc = '0, ex_ir = '0, ex_alu_out = '0, ex_b = '0;
    logic        mem_req, mem_we, mem_ack = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0]  mem_be;
    logic        wb_valid, wb_error;
    logic [31:0] wb_pc, wb_ir, wb_alu_out, wb_load_data;

    int tests = 0, fails = 0;
    int obs_lat, obs_reqs;
    logic [31:0] obs_addr, obs_wdata, obs_ld;
    logic [3:0]  obs_be;
    logic        obs_err;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_ir(ex_ir), .ex_alu_out(ex_alu_out), .ex_b(ex_b),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_ir(wb_ir), .wb_alu_out(wb_alu_out),
        .wb_load_data(wb_load_data), .wb_error(wb_error)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1);
    end

    function automatic logic [31:0] mk_ir(input logic [6:0] op, input logic [2:0] f3);
        return {17'h0, f3, 5'h1, op};
    endfunction

    // ackc = index of the request cycle on which ack is driven; 0 means never
    task automatic run_txn(input string name, input logic [31:0] pc, ir, alu, b, rd, input int ackc);
        bit ld, st, err, mem, tmo, stable;
        int size, a, elat, ereqs, lat, reqs;
        logic [2:0] f3;
        logic [3:0] ebe;
        logic [31:0] ewd, emask, eld, f_addr, f_wd;
        logic [3:0] f_be;
        logic f_we;
        logic [63:0] v, m;
        f3 = ir[14:12];
        a = int'(alu[1:0]);
        ld = ir[6:0] == 7'b0000011;
        st = ir[6:0] == 7'b0100011;
        if (ld) size = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : (f3 == 2) ? 4 : 0;
        else if (st) size = (f3 == 0) ? 1 : (f3 == 1) ? 2 : (f3 == 2) ? 4 : 0;
        else size = 0;
        err = (ld || st) && (size == 0 || (a % size) != 0);
        mem = (ld || st) && !err;
        tmo = mem && (ackc == 0 || ackc > TO);
        ebe = '0; ewd = '0; emask = '0;
        for (int i = 0; i < 4; i++)
            if (mem && i >= a && i < a + size) begin
                ebe[i] = 1'b1;
                emask[8*i +: 8] = 8'hFF;
                ewd[8*i +: 8] = b[8*(i-a) +: 8];
            end
        eld = '0;
        if (ld && mem && !tmo) begin
            m = (64'd1 << (8 * size)) - 1;
            v = (64'(rd) >> (8 * a)) & m;
            if (f3[2] == 1'b0 && size < 4 && v[8*size-1]) v = v | ~m;
            eld = v[31:0];
        end
        elat  = !mem ? 1 : tmo ? TO + 1 : ackc + 1;
        ereqs = !mem ? 0 : tmo ? TO : ackc;

        @(negedge clk);
        tests++;
        if (ex_ready !== 1'b1) begin fails++; $display("FAIL %s ready_before: got %b want 1", name, ex_ready); end
        ex_valid = 1'b1; ex_pc = pc; ex_ir = ir; ex_alu_out = alu; ex_b = b;
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        @(negedge clk);
        ex_valid = 1'b0; ex_pc = $urandom; ex_ir = $urandom; ex_alu_out = $urandom; ex_b = $urandom;
        lat = 0; reqs = 0; stable = 1'b1;
        f_addr = '0; f_wd = '0; f_be = '0; f_we = 1'b0;
        for (int c = 1; c <= TO + 4 && lat == 0; c++) begin
            if (mem_req) begin
                reqs++;
                if (reqs == 1) begin f_addr = mem_addr; f_wd = mem_wdata; f_be = mem_be; f_we = mem_we; end
                else if (mem_addr !== f_addr || mem_wdata !== f_wd || mem_be !== f_be || mem_we !== f_we) stable = 1'b0;
                mem_ack = (reqs == ackc);
                mem_rdata = (reqs == ackc) ? rd : $urandom;
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
            if (wb_valid) begin
                lat = c;
                obs_err = wb_error; obs_ld = wb_load_data;
                tests++;
                if (wb_pc !== pc || wb_ir !== ir || wb_alu_out !== alu) begin
                    fails++;
                    $display("FAIL %s wb_regs: got pc=%h ir=%h alu=%h want pc=%h ir=%h alu=%h",
                             name, wb_pc, wb_ir, wb_alu_out, pc, ir, alu);
                end
            end else @(negedge clk);
        end
        obs_lat = lat; obs_reqs = reqs; obs_addr = f_addr; obs_be = f_be; obs_wdata = f_wd;

        tests++;
        if (lat !== elat) begin fails++; $display("FAIL %s latency: got %0d want %0d", name, lat, elat); end
        tests++;
        if (reqs !== ereqs) begin fails++; $display("FAIL %s req_cycles: got %0d want %0d", name, reqs, ereqs); end
        tests++;
        if (obs_err !== (err || tmo)) begin fails++; $display("FAIL %s wb_error: got %b want %b", name, obs_err, err || tmo); end
        tests++;
        if (obs_ld !== eld) begin fails++; $display("FAIL %s wb_load_data: got %h want %h", name, obs_ld, eld); end
        if (ereqs > 0) begin
            tests++;
            if (f_addr !== {alu[31:2], 2'b00} || f_be !== ebe || f_we !== st || stable !== 1'b1) begin
                fails++;
                $display("FAIL %s mem_ctrl: got addr=%h be=%b we=%b stable=%b want addr=%h be=%b we=%b stable=1",
                         name, f_addr, f_be, f_we, stable, {alu[31:2], 2'b00}, ebe, st);
            end
            if (st) begin
                tests++;
                if ((f_wd & emask) !== ewd) begin fails++; $display("FAIL %s mem_wdata: got %h want %h (mask %h)", name, f_wd & emask, ewd, emask); end
            end
        end
        mem_ack = 1'b0;
        @(negedge clk);
        tests++;
        if (wb_valid !== 1'b0 || ex_ready !== 1'b1 || mem_req !== 1'b0 || wb_load_data !== eld) begin
            fails++;
            $display("FAIL %s after_resp: got valid=%b ready=%b req=%b ld=%h want 0 1 0 %h",
                     name, wb_valid, ex_ready, mem_req, wb_load_data, eld);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if ({ex_ready, mem_req, mem_we, wb_valid, wb_error} !== 5'b10000 ||
            (mem_addr | mem_wdata | wb_pc | wb_ir | wb_alu_out | wb_load_data) !== 32'h0 || mem_be !== 4'h0) begin
            fails++;
            $display("FAIL reset_state: got ready=%b req=%b we=%b valid=%b err=%b want 1 0 0 0 0 with zero data",
                     ex_ready, mem_req, mem_we, wb_valid, wb_error);
        end
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        run_txn("add", 32'h1000, 32'h00000033, 32'h00000123, 32'h5, 32'h0, 1);
        tests++;
        if (obs_lat !== 1 || obs_reqs !== 0) begin fails++; $display("FAIL add_lat: got lat=%0d reqs=%0d want 1 0", obs_lat, obs_reqs); end
    endtask

    task automatic test_load();
        run_txn("lb", 32'h1004, mk_ir(7'b0000011, 3'b000), 32'h103, 32'h0, 32'h80FF_1234, 1);
        tests++;
        if (obs_addr !== 32'h100 || obs_ld !== 32'hFFFF_FF80) begin
            fails++; $display("FAIL lb_direct: got addr=%h ld=%h want 00000100 ffffff80", obs_addr, obs_ld);
        end
        run_txn("lbu", 32'h1008, mk_ir(7'b0000011, 3'b100), 32'h103, 32'h0, 32'h80FF_1234, 2);
        tests++;
        if (obs_ld !== 32'h0000_0080) begin fails++; $display("FAIL lbu_direct: got %h want 00000080", obs_ld); end
    endtask

    task automatic test_store();
        run_txn("sh", 32'h100C, mk_ir(7'b0100011, 3'b001), 32'h202, 32'h0000_BEEF, 32'h0, 3);
        tests++;
        if (obs_be !== 4'b1100 || obs_wdata[31:16] !== 16'hBEEF || obs_reqs !== 3 || obs_lat !== 4) begin
            fails++;
            $display("FAIL sh_direct: got be=%b wd=%h reqs=%0d lat=%0d want 1100 beef 3 4",
                     obs_be, obs_wdata[31:16], obs_reqs, obs_lat);
        end
    endtask

    task automatic test_misaligned();
        run_txn("lw_mis", 32'h1010, mk_ir(7'b0000011, 3'b010), 32'h301, 32'h0, 32'hDEAD_BEEF, 1);
        tests++;
        if (obs_reqs !== 0 || obs_lat !== 1 || obs_err !== 1'b1 || obs_ld !== 32'h0) begin
            fails++;
            $display("FAIL lw_mis_direct: got reqs=%0d lat=%0d err=%b ld=%h want 0 1 1 0", obs_reqs, obs_lat, obs_err, obs_ld);
        end
    endtask

    task automatic test_timeout();
        run_txn("sw_tmo", 32'h1014, mk_ir(7'b0100011, 3'b010), 32'h400, 32'h1234_5678, 32'h0, 0);
        tests++;
        if (obs_reqs !== TO || obs_err !== 1'b1) begin
            fails++; $display("FAIL sw_tmo_direct: got reqs=%0d err=%b want %0d 1", obs_reqs, obs_err, TO);
        end
        run_txn("lw_ack_last", 32'h1018, mk_ir(7'b0000011, 3'b010), 32'h404, 32'h0, 32'hCAFE_F00D, TO);
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        ex_valid = 1'b1; ex_pc = 32'h2000; ex_ir = mk_ir(7'b0100011, 3'b010); ex_alu_out = 32'h500; ex_b = 32'h77;
        mem_ack = 1'b0;
        @(negedge clk);
        ex_valid = 1'b0;
        tests++;
        if (mem_req !== 1'b1) begin fails++; $display("FAIL rst_mid_setup: got req=%b want 1", mem_req); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (mem_req !== 1'b0 || ex_ready !== 1'b1 || wb_valid !== 1'b0 || mem_be !== 4'h0 || wb_pc !== 32'h0) begin
            fails++;
            $display("FAIL rst_mid_access: got req=%b ready=%b valid=%b be=%b pc=%h want 0 1 0 0000 0",
                     mem_req, ex_ready, wb_valid, mem_be, wb_pc);
        end
        @(negedge clk);
        rst = 1'b0;
        run_txn("post_rst", 32'h2004, mk_ir(7'b0000011, 3'b101), 32'h602, 32'h0, 32'h9876_5432, 2);
    endtask

    task automatic test_random();
        logic [31:0] ir;
        logic [6:0] ops [3];
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
        for (int n = 0; n < 60; n++) begin
            ir = $urandom;
            ir[6:0] = ($urandom_range(0, 4) == 0) ? 7'($urandom) : ops[$urandom_range(0, 2)];
            run_txn($sformatf("rand%0d", n), $urandom, ir, $urandom, $urandom, $urandom, $urandom_range(0, TO));
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_reset_mid_access();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
